// File: rtl/load_hazard_scoreboard.sv
// Per-register count of loads in flight between issue and writeback. It produces the
// ID stall / ID-EX bubble for load-use hazards that forwarding cannot cover.
module load_hazard_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 id_issue,
  input  logic [4:0]           id_rd_addr,
  input  logic                 id_mem_read,
  input  logic                 ex_flush,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_mem_read,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd_addr,
  input  logic                 wb_mem_read,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [5:0]           loads_pending,
  output logic                 sb_error
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 inc_ev, decf_ev, decw_ev;
  logic [CNT_WIDTH-1:0] cnt_q [REG_COUNT];
  logic [CNT_WIDTH-1:0] cnt_d [REG_COUNT];
  logic                 err_q, err_d;
  logic [5:0]           pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic                 hit_rs1, hit_rs2, full_block;

  // True when the register is still pending after discounting a same-cycle writeback.
  function automatic logic still_busy(input logic [CNT_WIDTH-1:0] c, input logic wb_hit);
    return c > CNT_WIDTH'(wb_hit);
  endfunction

  assign inc_ev  = id_issue & id_mem_read & (id_rd_addr != 5'd0);
  assign decf_ev = ex_flush & ex_mem_read & (ex_rd_addr != 5'd0);
  assign decw_ev = wb_valid & wb_mem_read & (wb_rd_addr != 5'd0);

  always_comb begin : next_state
    int net;
    net    = 0;
    err_d  = err_q;
    pend_d = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      net = int'(cnt_q[i]);
      if (inc_ev  && int'(id_rd_addr) == i) net = net + 1;
      if (decf_ev && int'(ex_rd_addr) == i) net = net - 1;
      if (decw_ev && int'(wb_rd_addr) == i) net = net - 1;
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (net < 0) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else if (net > int'(CNT_MAX)) begin
        cnt_d[i] = CNT_MAX;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = CNT_WIDTH'(net);
      end
      pend_d = pend_d + 6'(cnt_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) cnt_q[i] <= '0;
      err_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin : lookup
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rd  = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (int'(id_rs1_addr) == i) cnt_rs1 = cnt_q[i];
      if (int'(id_rs2_addr) == i) cnt_rs2 = cnt_q[i];
      if (int'(id_rd_addr)  == i) cnt_rd  = cnt_q[i];
    end
  end

  // A load writing back this cycle is forwardable from MEM/WB, so it does not hold readers.
  assign hit_rs1 = id_valid & id_use_rs1 & (id_rs1_addr != 5'd0) &
                   still_busy(cnt_rs1, decw_ev & (wb_rd_addr == id_rs1_addr));
  assign hit_rs2 = id_valid & id_use_rs2 & (id_rs2_addr != 5'd0) &
                   still_busy(cnt_rs2, decw_ev & (wb_rd_addr == id_rs2_addr));

  assign full_block = id_valid & id_mem_read & (cnt_rd == CNT_MAX) &
                      ~(decf_ev & (ex_rd_addr == id_rd_addr)) &
                      ~(decw_ev & (wb_rd_addr == id_rd_addr));

  assign stall_id  = hit_rs1 | hit_rs2 | full_block;
  assign bubble_ex = stall_id;

  always_comb begin : busy
    for (int i = 0; i < REG_COUNT; i++) busy_mask[i] = (cnt_q[i] != '0);
  end

  assign loads_pending = pend_q;
  assign sb_error      = err_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: directed scenarios plus random traffic checked
// against an array-of-counts model built from the scoreboard rules.
module tb_load_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_issue, id_mem_read;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ex_flush, ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        wb_valid, wb_mem_read;
  logic [4:0]  wb_rd_addr;
  logic        stall_id, bubble_ex, sb_error;
  logic [31:0] busy_mask;
  logic [5:0]  loads_pending;

  int mcnt [32];
  bit merr;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_hazard_scoreboard #(.REG_COUNT(32), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_issue(id_issue),
    .id_rd_addr(id_rd_addr), .id_mem_read(id_mem_read),
    .ex_flush(ex_flush), .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_mem_read(wb_mem_read),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .busy_mask(busy_mask),
    .loads_pending(loads_pending), .sb_error(sb_error)
  );

  // ---------------- reference model ----------------
  function automatic bit m_stall();
    bit dw, df, h1, h2, full;
    int e1, e2;
    dw = wb_valid && wb_mem_read && (wb_rd_addr != 0);
    df = ex_flush && ex_mem_read && (ex_rd_addr != 0);
    e1 = mcnt[id_rs1_addr] - ((dw && wb_rd_addr == id_rs1_addr) ? 1 : 0);
    e2 = mcnt[id_rs2_addr] - ((dw && wb_rd_addr == id_rs2_addr) ? 1 : 0);
    h1 = id_valid && id_use_rs1 && (id_rs1_addr != 0) && (e1 > 0);
    h2 = id_valid && id_use_rs2 && (id_rs2_addr != 0) && (e2 > 0);
    full = id_valid && id_mem_read && (mcnt[id_rd_addr] == 3) &&
           !(dw && wb_rd_addr == id_rd_addr) && !(df && ex_rd_addr == id_rd_addr);
    return h1 || h2 || full;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  function automatic logic [5:0] m_pending();
    int s = 0;
    for (int r = 1; r < 32; r++) s += mcnt[r];
    return 6'(s % 64);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic m_step();
    int n;
    for (int r = 1; r < 32; r++) begin
      n = mcnt[r];
      if (id_issue && id_mem_read && id_rd_addr == r) n++;
      if (ex_flush && ex_mem_read && ex_rd_addr == r) n--;
      if (wb_valid && wb_mem_read && wb_rd_addr == r) n--;
      if (n < 0) begin n = 0; merr = 1'b1; end
      if (n > 3) begin n = 3; merr = 1'b1; end
      mcnt[r] = n;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_issue = 0; id_mem_read = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    ex_flush = 0; ex_mem_read = 0; ex_rd_addr = 0;
    wb_valid = 0; wb_mem_read = 0; wb_rd_addr = 0;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_lw(input logic [4:0] rd);
    idle();
    id_valid = 1; id_issue = 1; id_mem_read = 1; id_rd_addr = rd;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    id_valid = 1'($urandom); id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    id_issue = 1'($urandom); id_mem_read = 1'($urandom);
    id_rs1_addr = 5'($urandom); id_rs2_addr = 5'($urandom); id_rd_addr = 5'($urandom);
    ex_flush = 1'($urandom); ex_mem_read = 1'($urandom); ex_rd_addr = 5'($urandom);
    wb_valid = 1'($urandom); wb_mem_read = 1'($urandom); wb_rd_addr = 5'($urandom);
    @(posedge clk);
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b exp=0", stall_id); end
    n_cmp++; if (bubble_ex !== 1'b0) begin n_bad++; $display("FAIL rst_bubble got=%0b exp=0", bubble_ex); end
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL rst_busy got=%h exp=0", busy_mask); end
    n_cmp++; if (loads_pending !== 6'd0) begin n_bad++; $display("FAIL rst_pending got=%0d exp=0", loads_pending); end
    n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0b exp=0", sb_error); end
    idle();
    rst_n = 1;
    m_reset();
    issue_lw(5'd5);
    tick();
    idle();
    #1;
    n_cmp++; if (busy_mask !== 32'h20) begin n_bad++; $display("FAIL rst_lw5_busy got=%h exp=00000020", busy_mask); end
    n_cmp++; if (loads_pending !== 6'd1) begin n_bad++; $display("FAIL rst_lw5_pending got=%0d exp=1", loads_pending); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue_lw(5'd5);
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL lu_t0_stall got=%0b exp=0", stall_id); end
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 5; id_use_rs1 = 1; id_rs2_addr = 1; id_use_rs2 = 1; id_rd_addr = 6;
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL lu_t1_stall got=%0b exp=1", stall_id); end
    n_cmp++; if (bubble_ex !== 1'b1) begin n_bad++; $display("FAIL lu_t1_bubble got=%0b exp=1", bubble_ex); end
    n_cmp++; if (busy_mask !== 32'h20) begin n_bad++; $display("FAIL lu_t1_busy got=%h exp=00000020", busy_mask); end
    tick();
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL lu_t2_stall got=%0b exp=1", stall_id); end
    tick();
    wb_valid = 1; wb_mem_read = 1; wb_rd_addr = 5; id_issue = 1;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL lu_t3_stall got=%0b exp=0", stall_id); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_mask[5] !== 1'b0) begin n_bad++; $display("FAIL lu_t4_busy5 got=%0b exp=0", busy_mask[5]); end
    n_cmp++; if (loads_pending !== 6'd0) begin n_bad++; $display("FAIL lu_t4_pending got=%0d exp=0", loads_pending); end
  endtask

  task automatic test_x0_unused();
    do_reset();
    issue_lw(5'd0);
    tick();
    idle();
    #1;
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL x0_busy got=%h exp=0", busy_mask); end
    n_cmp++; if (loads_pending !== 6'd0) begin n_bad++; $display("FAIL x0_pending got=%0d exp=0", loads_pending); end
    issue_lw(5'd5);
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 5; id_use_rs1 = 0; id_rs2_addr = 5; id_use_rs2 = 0;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL unused_stall got=%0b exp=0", stall_id); end
    id_use_rs2 = 1;
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL used_rs2_stall got=%0b exp=1", stall_id); end
    id_valid = 0;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL invalid_stall got=%0b exp=0", stall_id); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_lw(5'd7);
    tick();
    idle();
    ex_flush = 1; ex_mem_read = 1; ex_rd_addr = 7;
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 7; id_use_rs1 = 1;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL flush_reader_stall got=%0b exp=0", stall_id); end
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL flush_busy got=%h exp=0", busy_mask); end
    n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL flush_err_clean got=%0b exp=0", sb_error); end
    ex_flush = 1; ex_mem_read = 1; ex_rd_addr = 7;
    tick();
    idle();
    #1;
    n_cmp++; if (sb_error !== 1'b1) begin n_bad++; $display("FAIL flush_underflow_err got=%0b exp=1", sb_error); end
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (sb_error !== 1'b1) begin n_bad++; $display("FAIL flush_err_sticky got=%0b exp=1", sb_error); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue_lw(5'd9);
    tick();
    issue_lw(5'd9);
    wb_valid = 1; wb_mem_read = 1; wb_rd_addr = 9;
    tick();
    idle();
    #1;
    n_cmp++; if (loads_pending !== 6'd1) begin n_bad++; $display("FAIL same_inc_dec_pending got=%0d exp=1", loads_pending); end
    n_cmp++; if (busy_mask !== 32'h200) begin n_bad++; $display("FAIL same_inc_dec_busy got=%h exp=00000200", busy_mask); end
    for (int k = 0; k < 2; k++) begin
      issue_lw(5'd9);
      #1;
      n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL fill_stall k=%0d got=%0b exp=0", k, stall_id); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (loads_pending !== 6'd3) begin n_bad++; $display("FAIL full_pending got=%0d exp=3", loads_pending); end
    id_valid = 1; id_mem_read = 1; id_rd_addr = 9;
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL full_block got=%0b exp=1", stall_id); end
    tick();
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL full_block_hold got=%0b exp=1", stall_id); end
    wb_valid = 1; wb_mem_read = 1; wb_rd_addr = 9;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL full_release_wb got=%0b exp=0", stall_id); end
    tick();
    idle();
    #1;
    n_cmp++; if (loads_pending !== 6'd2) begin n_bad++; $display("FAIL after_wb_pending got=%0d exp=2", loads_pending); end
    n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL no_err_yet got=%0b exp=0", sb_error); end
    // Two loads pending: flush plus writeback in one cycle drains both cleanly.
    ex_flush = 1; ex_mem_read = 1; ex_rd_addr = 9;
    wb_valid = 1; wb_mem_read = 1; wb_rd_addr = 9;
    tick();
    idle();
    #1;
    n_cmp++; if (loads_pending !== 6'd0 || sb_error !== 1'b0) begin
      n_bad++; $display("FAIL fw_drain pending=%0d err=%0b exp pending=0 err=0", loads_pending, sb_error);
    end
    issue_lw(5'd9);
    tick();
    idle();
    ex_flush = 1; ex_mem_read = 1; ex_rd_addr = 9;
    wb_valid = 1; wb_mem_read = 1; wb_rd_addr = 9;
    tick();
    idle();
    #1;
    n_cmp++; if (loads_pending !== 6'd0) begin n_bad++; $display("FAIL fw_clamp_pending got=%0d exp=0", loads_pending); end
    n_cmp++; if (sb_error !== 1'b1) begin n_bad++; $display("FAIL fw_clamp_err got=%0b exp=1", sb_error); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue_lw(5'd5);
    tick();
    idle();
    id_valid = 1; id_rs1_addr = 5; id_use_rs1 = 1;
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL pre_rst_stall got=%0b exp=1", stall_id); end
    #1;
    rst_n = 0;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL async_rst_stall got=%0b exp=0", stall_id); end
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL async_rst_busy got=%h exp=0", busy_mask); end
    n_cmp++; if (loads_pending !== 6'd0) begin n_bad++; $display("FAIL async_rst_pending got=%0d exp=0", loads_pending); end
    m_reset();
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_mem_read = ($urandom_range(0, 2) == 0);
      ex_flush    = ($urandom_range(0, 9) == 0);
      ex_mem_read = 1'($urandom);
      ex_rd_addr  = 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_mem_read = ($urandom_range(0, 3) != 0);
      wb_rd_addr  = 5'($urandom_range(0, 7));
      id_issue    = id_valid && !m_stall() && ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (stall_id !== m_stall() || bubble_ex !== m_stall()) begin
        n_bad++; $display("FAIL rnd_stall cyc=%0d stall=%0b bubble=%0b exp=%0b", cyc, stall_id, bubble_ex, m_stall());
      end
      n_cmp++; if (busy_mask !== m_busy()) begin
        n_bad++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy_mask, m_busy());
      end
      n_cmp++; if (loads_pending !== m_pending()) begin
        n_bad++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", cyc, loads_pending, m_pending());
      end
      n_cmp++; if (sb_error !== merr) begin
        n_bad++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, sb_error, merr);
      end
      tick();
      if (cyc == 300) do_reset();
    end
    idle();
  endtask

  initial begin
    idle();
    m_reset();
    rst_n = 0;
    #2;
    test_reset();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_same_cycle();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
